// File: rtl/rpn_from_network_bridge_splitter.sv
// 1-to-4 AXI4-Stream demux from the network bridge RX path to the LAN/WAN/WNN/KIP RPN engines.
// Routes whole packets by the message type in beat 0; data path is a zero-latency pass-through.
module rpn_from_network_bridge_splitter #(
    parameter int AXIS_DATA_WIDTH          = 512,
    parameter int AXIS_KEEP_WIDTH          = 64,
    parameter int AXIS_FROM_NB_TDEST_WIDTH = 8,
    parameter int AXIS_FROM_NB_TUSER_WIDTH = 64,
    parameter int RPN_MSG_TYPE_WIDTH       = 8,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_LAN_PUB                        = 8'h01,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_LAN_ACK                        = 8'h02,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_LAN_SEQ_NUM_CHECK              = 8'h03,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_LAN_SEQ_NUM_REPLY              = 8'h04,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_PUB                        = 8'h10,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_ACK                        = 8'h11,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_REQUEST   = 8'h20,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_REPLY     = 8'h21,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_WRITE     = 8'h22,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_BRESP     = 8'h23,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_CHECK     = 8'h24,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_RDATA     = 8'h25,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_REQUEST   = 8'h26,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_REPLY     = 8'h27,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_WRITE     = 8'h28,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_BRESP     = 8'h29,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_NUM_SEQ_NUM_CHECK          = 8'h2A,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_NUM_SEQ_NUM_REPLY          = 8'h2B,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_SEQ_NUM_CHECK              = 8'h2C,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY              = 8'h2D,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_KIP_PUB                        = 8'h30,
    parameter logic [RPN_MSG_TYPE_WIDTH-1:0] RPN_MSG_TYPE_KIP_ACK                        = 8'h31
) (
    input  logic                                i_clk,
    input  logic                                i_ap_rst,

    input  logic                                from_network_bridge_tvalid,
    output logic                                from_network_bridge_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]          from_network_bridge_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]          from_network_bridge_tkeep,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tid,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tdest,
    input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_network_bridge_tuser,
    input  logic                                from_network_bridge_tlast,

    output logic                                to_rpn_LAN_tvalid,
    input  logic                                to_rpn_LAN_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_rpn_LAN_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_rpn_LAN_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_LAN_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_LAN_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_rpn_LAN_tuser,
    output logic                                to_rpn_LAN_tlast,

    output logic                                to_rpn_WAN_tvalid,
    input  logic                                to_rpn_WAN_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_rpn_WAN_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_rpn_WAN_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_WAN_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_WAN_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_rpn_WAN_tuser,
    output logic                                to_rpn_WAN_tlast,

    output logic                                to_rpn_WNN_tvalid,
    input  logic                                to_rpn_WNN_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_rpn_WNN_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_rpn_WNN_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_WNN_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_WNN_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_rpn_WNN_tuser,
    output logic                                to_rpn_WNN_tlast,

    output logic                                to_rpn_KIP_tvalid,
    input  logic                                to_rpn_KIP_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_rpn_KIP_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_rpn_KIP_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_KIP_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_rpn_KIP_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_rpn_KIP_tuser,
    output logic                                to_rpn_KIP_tlast
);

    typedef enum logic [0:0] {ST_HEAD = 1'b0, ST_BODY = 1'b1} state_e;
    typedef enum logic [2:0] {
        RT_DROP = 3'd0, RT_LAN = 3'd1, RT_WAN = 3'd2, RT_WNN = 3'd3, RT_KIP = 3'd4
    } route_e;

    function automatic route_e decode_route(input logic [RPN_MSG_TYPE_WIDTH-1:0] msg_type);
        route_e rt;
        case (msg_type)
            RPN_MSG_TYPE_LAN_PUB, RPN_MSG_TYPE_LAN_ACK,
            RPN_MSG_TYPE_LAN_SEQ_NUM_CHECK, RPN_MSG_TYPE_LAN_SEQ_NUM_REPLY:
                rt = RT_LAN;
            RPN_MSG_TYPE_WAN_PUB, RPN_MSG_TYPE_WAN_ACK:
                rt = RT_WAN;
            RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_REQUEST, RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_REPLY,
            RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_WRITE, RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_BRESP,
            RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_CHECK, RPN_MSG_TYPE_WAN_OUTGOING_SEQ_NUM_RDATA,
            RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_REQUEST, RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_REPLY,
            RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_WRITE, RPN_MSG_TYPE_WAN_INCOMING_SEQ_NUM_BRESP,
            RPN_MSG_TYPE_WAN_NUM_SEQ_NUM_CHECK, RPN_MSG_TYPE_WAN_NUM_SEQ_NUM_REPLY,
            RPN_MSG_TYPE_WAN_SEQ_NUM_CHECK, RPN_MSG_TYPE_WAN_SEQ_NUM_REPLY:
                rt = RT_WNN;
            RPN_MSG_TYPE_KIP_PUB, RPN_MSG_TYPE_KIP_ACK:
                rt = RT_KIP;
            default:
                rt = RT_DROP;
        endcase
        return rt;
    endfunction

    state_e state_q, state_d;
    route_e route_q, route_d;
    route_e live_route_s;
    route_e route_s;
    logic   accept_s;

    // Route selection: live decode on the head beat, latched route for the rest of the packet
    always_comb begin
        live_route_s = decode_route(from_network_bridge_tdata[RPN_MSG_TYPE_WIDTH-1:0]);
        if (state_q == ST_BODY) begin
            route_s = route_q;
        end else begin
            route_s = live_route_s;
        end
    end

    // Handshake steering; tvalid is derived only from input tvalid and the route, never from tready
    always_comb begin
        to_rpn_LAN_tvalid          = 1'b0;
        to_rpn_WAN_tvalid          = 1'b0;
        to_rpn_WNN_tvalid          = 1'b0;
        to_rpn_KIP_tvalid          = 1'b0;
        from_network_bridge_tready = 1'b0;
        if (i_ap_rst) begin
            from_network_bridge_tready = 1'b0;
        end else begin
            case (route_s)
                RT_LAN: begin
                    to_rpn_LAN_tvalid          = from_network_bridge_tvalid;
                    from_network_bridge_tready = to_rpn_LAN_tready;
                end
                RT_WAN: begin
                    to_rpn_WAN_tvalid          = from_network_bridge_tvalid;
                    from_network_bridge_tready = to_rpn_WAN_tready;
                end
                RT_WNN: begin
                    to_rpn_WNN_tvalid          = from_network_bridge_tvalid;
                    from_network_bridge_tready = to_rpn_WNN_tready;
                end
                RT_KIP: begin
                    to_rpn_KIP_tvalid          = from_network_bridge_tvalid;
                    from_network_bridge_tready = to_rpn_KIP_tready;
                end
                default: begin
                    // Unknown message types are swallowed so they cannot stall the bridge
                    from_network_bridge_tready = 1'b1;
                end
            endcase
        end
    end

    assign accept_s = from_network_bridge_tvalid & from_network_bridge_tready;

    // Packet lock next-state: latch route on a non-final head beat, release on the final beat
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            ST_HEAD: begin
                if (accept_s && !from_network_bridge_tlast) begin
                    state_d = ST_BODY;
                    route_d = live_route_s;
                end else begin
                    state_d = ST_HEAD;
                end
            end
            ST_BODY: begin
                if (accept_s && from_network_bridge_tlast) begin
                    state_d = ST_HEAD;
                end else begin
                    state_d = ST_BODY;
                end
            end
            default: begin
                state_d = ST_HEAD;
                route_d = RT_DROP;
            end
        endcase
    end

    // Packet lock state and latched route registers
    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) begin
            state_q <= ST_HEAD;
            route_q <= RT_DROP;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    assign to_rpn_LAN_tdata = from_network_bridge_tdata;
    assign to_rpn_LAN_tkeep = from_network_bridge_tkeep;
    assign to_rpn_LAN_tid   = from_network_bridge_tid;
    assign to_rpn_LAN_tdest = from_network_bridge_tdest;
    assign to_rpn_LAN_tuser = from_network_bridge_tuser;
    assign to_rpn_LAN_tlast = from_network_bridge_tlast;

    assign to_rpn_WAN_tdata = from_network_bridge_tdata;
    assign to_rpn_WAN_tkeep = from_network_bridge_tkeep;
    assign to_rpn_WAN_tid   = from_network_bridge_tid;
    assign to_rpn_WAN_tdest = from_network_bridge_tdest;
    assign to_rpn_WAN_tuser = from_network_bridge_tuser;
    assign to_rpn_WAN_tlast = from_network_bridge_tlast;

    assign to_rpn_WNN_tdata = from_network_bridge_tdata;
    assign to_rpn_WNN_tkeep = from_network_bridge_tkeep;
    assign to_rpn_WNN_tid   = from_network_bridge_tid;
    assign to_rpn_WNN_tdest = from_network_bridge_tdest;
    assign to_rpn_WNN_tuser = from_network_bridge_tuser;
    assign to_rpn_WNN_tlast = from_network_bridge_tlast;

    assign to_rpn_KIP_tdata = from_network_bridge_tdata;
    assign to_rpn_KIP_tkeep = from_network_bridge_tkeep;
    assign to_rpn_KIP_tid   = from_network_bridge_tid;
    assign to_rpn_KIP_tdest = from_network_bridge_tdest;
    assign to_rpn_KIP_tuser = from_network_bridge_tuser;
    assign to_rpn_KIP_tlast = from_network_bridge_tlast;

endmodule

// File: tb/tb_rpn_from_network_bridge_splitter.sv
// Self-checking bench for rpn_from_network_bridge_splitter: randomized beats compared against a
// packet-level routing model built from per-engine code lists.
module tb_rpn_from_network_bridge_splitter;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int TW = 8;
    localparam int UW = 64;

    localparam logic [KW-1:0] C_KEEP = 64'hEFEFEFEFEFEFEFEF;
    localparam logic [UW-1:0] C_USER = {16'hACAC, 16'hBBBB, 32'h0C0D0E0F};
    localparam logic [TW-1:0] C_DEST = 8'hAB;

    logic [7:0] lan_codes[4]  = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] wan_codes[2]  = '{8'h10, 8'h11};
    logic [7:0] wnn_codes[14] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                  8'h27, 8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D};
    logic [7:0] kip_codes[2]  = '{8'h30, 8'h31};

    logic          clk = 1'b0;
    logic          rst;
    logic          in_tvalid, in_tready, in_tlast;
    logic [DW-1:0] in_tdata;
    logic [KW-1:0] in_tkeep;
    logic [TW-1:0] in_tid, in_tdest;
    logic [UW-1:0] in_tuser;
    logic          lan_tvalid, lan_tready, lan_tlast;
    logic          wan_tvalid, wan_tready, wan_tlast;
    logic          wnn_tvalid, wnn_tready, wnn_tlast;
    logic          kip_tvalid, kip_tready, kip_tlast;
    logic [DW-1:0] lan_tdata, wan_tdata, wnn_tdata, kip_tdata;
    logic [KW-1:0] lan_tkeep, wan_tkeep, wnn_tkeep, kip_tkeep;
    logic [TW-1:0] lan_tid, wan_tid, wnn_tid, kip_tid;
    logic [TW-1:0] lan_tdest, wan_tdest, wnn_tdest, kip_tdest;
    logic [UW-1:0] lan_tuser, wan_tuser, wnn_tuser, kip_tuser;

    int checks = 0;
    int failures = 0;

    // Model: packet in progress flag and locked engine (0 drop, 1 LAN, 2 WAN, 3 WNN, 4 KIP)
    bit m_in_packet = 1'b0;
    int m_locked    = 0;

    always #5 clk = ~clk;

    rpn_from_network_bridge_splitter dut (
        .i_clk(clk), .i_ap_rst(rst),
        .from_network_bridge_tvalid(in_tvalid), .from_network_bridge_tready(in_tready),
        .from_network_bridge_tdata(in_tdata), .from_network_bridge_tkeep(in_tkeep),
        .from_network_bridge_tid(in_tid), .from_network_bridge_tdest(in_tdest),
        .from_network_bridge_tuser(in_tuser), .from_network_bridge_tlast(in_tlast),
        .to_rpn_LAN_tvalid(lan_tvalid), .to_rpn_LAN_tready(lan_tready), .to_rpn_LAN_tdata(lan_tdata),
        .to_rpn_LAN_tkeep(lan_tkeep), .to_rpn_LAN_tid(lan_tid), .to_rpn_LAN_tdest(lan_tdest),
        .to_rpn_LAN_tuser(lan_tuser), .to_rpn_LAN_tlast(lan_tlast),
        .to_rpn_WAN_tvalid(wan_tvalid), .to_rpn_WAN_tready(wan_tready), .to_rpn_WAN_tdata(wan_tdata),
        .to_rpn_WAN_tkeep(wan_tkeep), .to_rpn_WAN_tid(wan_tid), .to_rpn_WAN_tdest(wan_tdest),
        .to_rpn_WAN_tuser(wan_tuser), .to_rpn_WAN_tlast(wan_tlast),
        .to_rpn_WNN_tvalid(wnn_tvalid), .to_rpn_WNN_tready(wnn_tready), .to_rpn_WNN_tdata(wnn_tdata),
        .to_rpn_WNN_tkeep(wnn_tkeep), .to_rpn_WNN_tid(wnn_tid), .to_rpn_WNN_tdest(wnn_tdest),
        .to_rpn_WNN_tuser(wnn_tuser), .to_rpn_WNN_tlast(wnn_tlast),
        .to_rpn_KIP_tvalid(kip_tvalid), .to_rpn_KIP_tready(kip_tready), .to_rpn_KIP_tdata(kip_tdata),
        .to_rpn_KIP_tkeep(kip_tkeep), .to_rpn_KIP_tid(kip_tid), .to_rpn_KIP_tdest(kip_tdest),
        .to_rpn_KIP_tuser(kip_tuser), .to_rpn_KIP_tlast(kip_tlast)
    );

    logic [4:0] obs_vec;
    assign obs_vec = {lan_tvalid, wan_tvalid, wnn_tvalid, kip_tvalid, in_tready};

    function automatic int engine_of(input logic [7:0] code);
        foreach (lan_codes[i]) if (lan_codes[i] == code) return 1;
        foreach (wan_codes[i]) if (wan_codes[i] == code) return 2;
        foreach (wnn_codes[i]) if (wnn_codes[i] == code) return 3;
        foreach (kip_codes[i]) if (kip_codes[i] == code) return 4;
        return 0;
    endfunction

    function automatic int cur_engine();
        return m_in_packet ? m_locked : engine_of(in_tdata[7:0]);
    endfunction

    // Expected {LAN,WAN,WNN,KIP tvalid, in tready} from the current bench-driven inputs
    function automatic logic [4:0] exp_vec();
        int e;
        logic [3:0] sel;
        logic rdy;
        if (rst) return 5'b0;
        e   = cur_engine();
        sel = (e == 0) ? 4'b0000 : (4'b1000 >> (e - 1));
        case (e)
            1: rdy = lan_tready;
            2: rdy = wan_tready;
            3: rdy = wnn_tready;
            4: rdy = kip_tready;
            default: rdy = 1'b1;
        endcase
        return {(in_tvalid ? sel : 4'b0000), rdy};
    endfunction

    task automatic drive(input logic v, input logic [7:0] code, input logic last, input logic [3:0] rdy);
        for (int i = 0; i < DW / 32; i++) in_tdata[i*32 +: 32] = $urandom;
        in_tdata[7:0] = code;
        in_tvalid  = v;
        in_tlast   = last;
        in_tkeep   = C_KEEP;
        in_tid     = C_DEST;
        in_tdest   = C_DEST;
        in_tuser   = C_USER;
        {lan_tready, wan_tready, wnn_tready, kip_tready} = rdy;
        #2;
    endtask

    // Advance one clock and let the model see any accepted beat
    task automatic tick();
        logic [4:0] e;
        @(posedge clk);
        e = exp_vec();
        if (!rst && in_tvalid && e[0]) begin
            if (m_in_packet) begin
                if (in_tlast) m_in_packet = 1'b0;
            end else if (!in_tlast) begin
                m_in_packet = 1'b1;
                m_locked    = engine_of(in_tdata[7:0]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_in_packet = 1'b0;
        m_locked = 0;
        drive(1'b1, 8'h01, 1'b1, 4'b1111);
        checks++;
        if (obs_vec !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=%b", obs_vec, 5'b00000);
        end
        tick();
        #2 rst = 1'b0;
        drive(1'b1, 8'h01, 1'b1, 4'b1000);
        checks++;
        if (obs_vec !== 5'b10001) begin
            failures++;
            $display("FAIL reset_release got=%b want=%b", obs_vec, 5'b10001);
        end
        tick();
    endtask

    task automatic test_lan();
        logic [4:0] e;
        foreach (lan_codes[i]) begin
            for (int r = 0; r < 2; r++) begin
                drive(1'b1, lan_codes[i], 1'b1, (r == 1) ? 4'b1000 : 4'b0111);
                e = exp_vec();
                checks++;
                if (obs_vec !== e) begin
                    failures++;
                    $display("FAIL lan_route code=%h got=%b want=%b", lan_codes[i], obs_vec, e);
                end
                checks++;
                if (lan_tdata !== in_tdata || lan_tuser !== C_USER || lan_tdest !== C_DEST) begin
                    failures++;
                    $display("FAIL lan_fields user=%h dest=%h want user=%h dest=%h",
                             lan_tuser, lan_tdest, C_USER, C_DEST);
                end
                tick();
            end
        end
    endtask

    task automatic test_wan();
        logic [4:0] e;
        foreach (wan_codes[i]) begin
            drive(1'b1, wan_codes[i], 1'b1, 4'b1011);
            e = exp_vec();
            checks++;
            if (obs_vec !== e || e !== 5'b01000) begin
                failures++;
                $display("FAIL wan_route code=%h got=%b want=%b", wan_codes[i], obs_vec, e);
            end
            tick();
        end
    endtask

    task automatic test_wnn();
        logic [4:0] e;
        foreach (wnn_codes[i]) begin
            drive(1'b1, wnn_codes[i], 1'b1, {1'b1, 1'b1, 1'(i % 2), 1'b1});
            e = exp_vec();
            checks++;
            if (obs_vec !== e) begin
                failures++;
                $display("FAIL wnn_route code=%h got=%b want=%b", wnn_codes[i], obs_vec, e);
            end
            tick();
        end
    endtask

    task automatic test_kip();
        logic [4:0] e;
        foreach (kip_codes[i]) begin
            drive(1'b1, kip_codes[i], 1'b1, 4'b0001);
            e = exp_vec();
            checks++;
            if (obs_vec !== e) begin
                failures++;
                $display("FAIL kip_route code=%h got=%b want=%b", kip_codes[i], obs_vec, e);
            end
            checks++;
            if (kip_tuser !== 64'hACACBBBB0C0D0E0F || kip_tkeep !== C_KEEP || kip_tid !== C_DEST) begin
                failures++;
                $display("FAIL kip_fields user=%h keep=%h want user=%h keep=%h",
                         kip_tuser, kip_tkeep, 64'hACACBBBB0C0D0E0F, C_KEEP);
            end
            tick();
        end
    endtask

    task automatic test_multi_beat();
        drive(1'b1, 8'h30, 1'b0, 4'b1111);
        checks++;
        if (obs_vec !== 5'b00011) begin
            failures++;
            $display("FAIL multi_head got=%b want=%b", obs_vec, 5'b00011);
        end
        tick();
        drive(1'b1, 8'h01, 1'b1, 4'b1111);
        checks++;
        if (obs_vec !== 5'b00011) begin
            failures++;
            $display("FAIL multi_body_locked got=%b want=%b", obs_vec, 5'b00011);
        end
        tick();
        drive(1'b1, 8'h01, 1'b1, 4'b1111);
        checks++;
        if (obs_vec !== 5'b10001) begin
            failures++;
            $display("FAIL multi_next_head got=%b want=%b", obs_vec, 5'b10001);
        end
        tick();
    endtask

    task automatic test_drop();
        drive(1'b1, 8'hFF, 1'b1, 4'b0000);
        checks++;
        if (obs_vec !== 5'b00001) begin
            failures++;
            $display("FAIL drop_unknown got=%b want=%b", obs_vec, 5'b00001);
        end
        tick();
        // Type changes while stalled in the head: routing follows the live code
        drive(1'b1, 8'h10, 1'b0, 4'b0000);
        drive(1'b1, 8'h31, 1'b0, 4'b1110);
        checks++;
        if (obs_vec !== 5'b00010) begin
            failures++;
            $display("FAIL head_retarget got=%b want=%b", obs_vec, 5'b00010);
        end
        tick();
    endtask

    task automatic test_reset_mid_packet();
        drive(1'b1, 8'h30, 1'b0, 4'b1111);
        tick();
        #1 rst = 1'b1;
        m_in_packet = 1'b0;
        m_locked = 0;
        #2 rst = 1'b0;
        drive(1'b1, 8'h10, 1'b1, 4'b1111);
        checks++;
        if (obs_vec !== 5'b01001) begin
            failures++;
            $display("FAIL reset_mid_packet got=%b want=%b", obs_vec, 5'b01001);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        logic [7:0] code;
        logic [DW-1:0] sel_data;
        int len, pick;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
                pick = $urandom_range(0, 4);
                case (pick)
                    0: code = lan_codes[$urandom_range(0, 3)];
                    1: code = wan_codes[$urandom_range(0, 1)];
                    2: code = wnn_codes[$urandom_range(0, 13)];
                    3: code = kip_codes[$urandom_range(0, 1)];
                    default: code = 8'($urandom);
                endcase
                do begin
                    drive(($urandom_range(0, 3) != 0), code, (b == len - 1), 4'($urandom));
                    e = exp_vec();
                    checks++;
                    if (obs_vec !== e) begin
                        failures++;
                        $display("FAIL b2b_route pkt=%0d beat=%0d code=%h got=%b want=%b",
                                 p, b, code, obs_vec, e);
                    end
                    case (pick)
                        0: sel_data = lan_tdata;
                        1: sel_data = wan_tdata;
                        2: sel_data = wnn_tdata;
                        default: sel_data = kip_tdata;
                    endcase
                    checks++;
                    if (sel_data !== in_tdata) begin
                        failures++;
                        $display("FAIL b2b_data pkt=%0d beat=%0d got=%h want=%h",
                                 p, b, sel_data[63:0], in_tdata[63:0]);
                    end
                    tick();
                end while (!(in_tvalid && e[0]));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 4'b0000);
        @(negedge clk);
        test_reset();
        test_lan();
        test_wan();
        test_wnn();
        test_kip();
        test_multi_beat();
        test_drop();
        test_reset_mid_packet();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
